// File: rtl/control_unit_if.sv
// Control bundle between the hardwired control unit and the Mini-SRC datapath.
// IR/CON_Out flow into the unit; every strobe, OP, Run and the state tap flow out.
interface control_unit_if;
   logic [31:0] IR;
   logic        CON_Out;
   logic        PCin, IRin, HIin, LOin, ZHighin, ZLowin, MARin, MDRin, Yin, OutPort;
   logic        PCout, HIout, LOout, ZHighout, ZLowout, MDRout, InPort, Cout, Rout, BAout;
   logic        Gra, Grb, Grc, Rin;
   logic        Read, Write, IncPC, CON_In;
   logic [4:0]  OP;
   logic        Run;
   logic [3:0]  state_dbg;

   // No handshake: every strobe is a level valid for the whole state, and the
   // datapath captures on the rising edge that ends that state.
   modport master (
      input  IR, CON_Out,
      output PCin, IRin, HIin, LOin, ZHighin, ZLowin, MARin, MDRin, Yin, OutPort,
      output PCout, HIout, LOout, ZHighout, ZLowout, MDRout, InPort, Cout, Rout, BAout,
      output Gra, Grb, Grc, Rin, Read, Write, IncPC, CON_In, OP, Run, state_dbg
   );

   modport slave (
      output IR, CON_Out,
      input  PCin, IRin, HIin, LOin, ZHighin, ZLowin, MARin, MDRin, Yin, OutPort,
      input  PCout, HIout, LOout, ZHighout, ZLowout, MDRout, InPort, Cout, Rout, BAout,
      input  Gra, Grb, Grc, Rin, Read, Write, IncPC, CON_In, OP, Run, state_dbg
   );
endinterface

// File: rtl/control_unit.sv
// Hardwired Mini-SRC control unit: Moore FSM stepping fetch T0-T2 and the
// per-opcode execute steps T3-T7, one control step per clock.
module control_unit (
   input  logic           Clock,
   input  logic           Clear,
   control_unit_if.master bus
);
   typedef enum logic [3:0] {
      S_T0 = 4'd0, S_T1 = 4'd1, S_T2 = 4'd2, S_T3 = 4'd3,
      S_T4 = 4'd4, S_T5 = 4'd5, S_T6 = 4'd6, S_T7 = 4'd7,
      S_RESET = 4'd8, S_HALT = 4'd9
   } state_e;

   localparam logic [4:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011, OP_ROL  = 5'b01011, OP_ADDI = 5'b01100;
   localparam logic [4:0] OP_ORI  = 5'b01110, OP_MUL  = 5'b01111, OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001, OP_NOT  = 5'b10010, OP_BR   = 5'b10011;
   localparam logic [4:0] OP_JR   = 5'b10100, OP_JAL  = 5'b10101, OP_IN   = 5'b10110;
   localparam logic [4:0] OP_OUT  = 5'b10111, OP_MFHI = 5'b11000, OP_MFLO = 5'b11001;
   localparam logic [4:0] OP_HALT = 5'b11011;

   state_e     state, state_next;
   logic [4:0] opc;
   logic       is_ralu, is_ialu, is_negnot, is_muldiv, is_mem, is_short;
   logic [2:0] last_step;
   logic       unused_ir;

   assign opc       = bus.IR[31:27];
   assign unused_ir = ^bus.IR[26:0];

   assign is_ralu   = (opc >= OP_ADD) && (opc <= OP_ROL);
   assign is_ialu   = (opc >= OP_ADDI) && (opc <= OP_ORI);
   assign is_negnot = (opc == OP_NEG) || (opc == OP_NOT);
   assign is_muldiv = (opc == OP_MUL) || (opc == OP_DIV);
   assign is_mem    = (opc == OP_LD) || (opc == OP_LDI) || (opc == OP_ST);
   assign is_short  = (opc == OP_JR) || (opc == OP_IN) || (opc == OP_OUT) ||
                      (opc == OP_MFHI) || (opc == OP_MFLO);

   // Final control step of each instruction class; 2 means fetch-only (nop, undefined).
   always_comb begin
      last_step = 3'd2;
      if (is_short)                                   last_step = 3'd3;
      else if ((opc == OP_JAL) || is_negnot)          last_step = 3'd4;
      else if (is_ralu || is_ialu || opc == OP_LDI)   last_step = 3'd5;
      else if (is_muldiv || opc == OP_BR)             last_step = 3'd6;
      else if ((opc == OP_LD) || (opc == OP_ST))      last_step = 3'd7;
   end

   always_ff @(posedge Clock or posedge Clear) begin
      if (Clear) state <= S_RESET;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_RESET: state_next = S_T0;
         S_T0:    state_next = S_T1;
         S_T1:    state_next = S_T2;
         S_T2: begin
            if (opc == OP_HALT)         state_next = S_HALT;
            else if (last_step == 3'd2) state_next = S_T0;
            else                        state_next = S_T3;
         end
         S_HALT:  state_next = S_HALT;
         default: begin
            if (state[2:0] == last_step) state_next = S_T0;
            else                         state_next = state_e'(state + 4'd1);
         end
      endcase
   end

   always_comb begin
      bus.PCin = 1'b0;    bus.IRin = 1'b0;    bus.HIin = 1'b0;     bus.LOin = 1'b0;
      bus.ZHighin = 1'b0; bus.ZLowin = 1'b0;  bus.MARin = 1'b0;    bus.MDRin = 1'b0;
      bus.Yin = 1'b0;     bus.OutPort = 1'b0; bus.PCout = 1'b0;    bus.HIout = 1'b0;
      bus.LOout = 1'b0;   bus.ZHighout = 1'b0; bus.ZLowout = 1'b0; bus.MDRout = 1'b0;
      bus.InPort = 1'b0;  bus.Cout = 1'b0;    bus.Rout = 1'b0;     bus.BAout = 1'b0;
      bus.Gra = 1'b0;     bus.Grb = 1'b0;     bus.Grc = 1'b0;      bus.Rin = 1'b0;
      bus.Read = 1'b0;    bus.Write = 1'b0;   bus.IncPC = 1'b0;    bus.CON_In = 1'b0;
      bus.OP = 5'b00000;
      bus.Run = (state != S_RESET) && (state != S_HALT);
      bus.state_dbg = state;
      case (state)
         S_T0: begin bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.ZLowin = 1'b1; end
         S_T1: begin bus.ZLowout = 1'b1; bus.PCin = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1; end
         S_T2: begin bus.MDRout = 1'b1; bus.IRin = 1'b1; end
         S_T3: begin
            if (is_ralu || is_ialu) begin
               bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
            end else if (is_negnot) begin
               bus.Grb = 1'b1; bus.Rout = 1'b1; bus.OP = opc; bus.ZLowin = 1'b1;
            end else if (is_muldiv) begin
               bus.Gra = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
            end else if (is_mem) begin
               bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1;
            end else begin
               case (opc)
                  OP_BR:   begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.CON_In = 1'b1; end
                  OP_JR:   begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.PCin = 1'b1; end
                  OP_JAL:  begin bus.PCout = 1'b1; bus.Grb = 1'b1; bus.Rin = 1'b1; end
                  OP_IN:   begin bus.InPort = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
                  OP_OUT:  begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.OutPort = 1'b1; end
                  OP_MFHI: begin bus.HIout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
                  OP_MFLO: begin bus.LOout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
                  default: ;
               endcase
            end
         end
         S_T4: begin
            if (is_ralu || is_muldiv) begin
               bus.Grc = is_ralu; bus.Grb = is_muldiv; bus.Rout = 1'b1;
               bus.OP = opc; bus.ZHighin = 1'b1; bus.ZLowin = 1'b1;
            end else if (is_ialu) begin
               bus.Cout = 1'b1; bus.OP = opc; bus.ZHighin = 1'b1; bus.ZLowin = 1'b1;
            end else if (is_negnot) begin
               bus.ZLowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
            end else if (is_mem) begin
               bus.Cout = 1'b1; bus.OP = OP_ADD; bus.ZLowin = 1'b1;
            end else if (opc == OP_BR) begin
               bus.PCout = 1'b1; bus.Yin = 1'b1;
            end else if (opc == OP_JAL) begin
               bus.Gra = 1'b1; bus.Rout = 1'b1; bus.PCin = 1'b1;
            end
         end
         S_T5: begin
            if (is_ralu || is_ialu || opc == OP_LDI) begin
               bus.ZLowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
            end else if (is_muldiv) begin
               bus.ZLowout = 1'b1; bus.LOin = 1'b1;
            end else if ((opc == OP_LD) || (opc == OP_ST)) begin
               bus.ZLowout = 1'b1; bus.MARin = 1'b1;
            end else if (opc == OP_BR) begin
               bus.Cout = 1'b1; bus.OP = OP_ADD; bus.ZLowin = 1'b1;
            end
         end
         S_T6: begin
            if (is_muldiv) begin
               bus.ZHighout = 1'b1; bus.HIin = 1'b1;
            end else if (opc == OP_LD) begin
               bus.Read = 1'b1; bus.MDRin = 1'b1;
            end else if (opc == OP_ST) begin
               bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDRin = 1'b1;
            end else if (opc == OP_BR) begin
               bus.ZLowout = bus.CON_Out; bus.PCin = bus.CON_Out;
            end
         end
         S_T7: begin
            if (opc == OP_LD) begin
               bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
            end else if (opc == OP_ST) begin
               bus.Write = 1'b1;
            end
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: the driver queues hand-written per-cycle strobe vectors,
// a negedge monitor pops and compares one vector per clock.
module tb_control_unit;
   localparam int W = 40;

   logic Clock = 1'b0;
   logic Clear = 1'b1;

   control_unit_if bus ();
   control_unit dut (.Clock(Clock), .Clear(Clear), .bus(bus));

   always #5 Clock = ~Clock;

   localparam logic [W-1:0] ZERO     = '0;
   localparam logic [W-1:0] PCIN     = 40'd1 << 0;
   localparam logic [W-1:0] IRIN     = 40'd1 << 1;
   localparam logic [W-1:0] HIIN     = 40'd1 << 2;
   localparam logic [W-1:0] LOIN     = 40'd1 << 3;
   localparam logic [W-1:0] ZHIGHIN  = 40'd1 << 4;
   localparam logic [W-1:0] ZLOWIN   = 40'd1 << 5;
   localparam logic [W-1:0] MARIN    = 40'd1 << 6;
   localparam logic [W-1:0] MDRIN    = 40'd1 << 7;
   localparam logic [W-1:0] YIN      = 40'd1 << 8;
   localparam logic [W-1:0] OUTPORT  = 40'd1 << 9;
   localparam logic [W-1:0] PCOUT    = 40'd1 << 10;
   localparam logic [W-1:0] HIOUT    = 40'd1 << 11;
   localparam logic [W-1:0] LOOUT    = 40'd1 << 12;
   localparam logic [W-1:0] ZHIGHOUT = 40'd1 << 13;
   localparam logic [W-1:0] ZLOWOUT  = 40'd1 << 14;
   localparam logic [W-1:0] MDROUT   = 40'd1 << 15;
   localparam logic [W-1:0] INPORT   = 40'd1 << 16;
   localparam logic [W-1:0] COUT     = 40'd1 << 17;
   localparam logic [W-1:0] ROUT     = 40'd1 << 18;
   localparam logic [W-1:0] BAOUT    = 40'd1 << 19;
   localparam logic [W-1:0] GRA      = 40'd1 << 20;
   localparam logic [W-1:0] GRB      = 40'd1 << 21;
   localparam logic [W-1:0] GRC      = 40'd1 << 22;
   localparam logic [W-1:0] RIN      = 40'd1 << 23;
   localparam logic [W-1:0] READ     = 40'd1 << 24;
   localparam logic [W-1:0] WRITE    = 40'd1 << 25;
   localparam logic [W-1:0] INCPC    = 40'd1 << 26;
   localparam logic [W-1:0] CONIN    = 40'd1 << 27;
   localparam logic [W-1:0] RUN      = 40'd1 << 37;

   logic [W-1:0] act;
   assign act = {2'b00, bus.Run, bus.OP, 4'b0000,
                 bus.CON_In, bus.IncPC, bus.Write, bus.Read, bus.Rin, bus.Grc, bus.Grb, bus.Gra,
                 bus.BAout, bus.Rout, bus.Cout, bus.InPort, bus.MDRout, bus.ZLowout,
                 bus.ZHighout, bus.LOout, bus.HIout, bus.PCout, bus.OutPort, bus.Yin,
                 bus.MDRin, bus.MARin, bus.ZLowin, bus.ZHighin, bus.LOin, bus.HIin,
                 bus.IRin, bus.PCin};

   logic [W-1:0] exp_q[$];
   string        name_q[$];
   int           n_tests = 0;
   int           n_fail  = 0;
   logic [W-1:0] exp_v;
   string        exp_n;

   function automatic logic [W-1:0] opf(input logic [4:0] o);
      return {3'b000, o, 32'h0};
   endfunction

   // Scoreboard monitor: one expected vector per clock, compared mid-cycle.
   always @(negedge Clock) begin
      if (exp_q.size() != 0) begin
         exp_v = exp_q.pop_front();
         exp_n = name_q.pop_front();
         n_tests++;
         if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", exp_n, act, exp_v);
         end
      end
   end

   task automatic push(input logic [W-1:0] v, input string n);
      exp_q.push_back(v);
      name_q.push_back(n);
   endtask

   task automatic pr(input logic [W-1:0] v, input string n);
      push(v | RUN, n);
   endtask

   task automatic start(input logic [31:0] ir, input logic con, input string tag);
      bus.IR      = ir;
      bus.CON_Out = con;
      pr(PCOUT | MARIN | INCPC | ZLOWIN, {tag, ".T0"});
      pr(ZLOWOUT | PCIN | READ | MDRIN, {tag, ".T1"});
      pr(MDROUT | IRIN, {tag, ".T2"});
   endtask

   task automatic drain();
      int guard = 0;
      while (exp_q.size() != 0 && guard < 200) begin
         @(posedge Clock);
         #1;
         guard++;
      end
      if (exp_q.size() != 0) begin
         $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
         $fatal(1, "scoreboard stalled");
      end
   endtask

   function automatic logic [31:0] ir_of(input logic [4:0] o);
      return {o, 27'h0};
   endfunction

   initial begin
      bus.IR      = '0;
      bus.CON_Out = 1'b0;
      @(posedge Clock);
      #1;
      push(ZERO, "reset_state");
      drain();

      Clear = 1'b0;
      push(ZERO, "reset_release");
      start(32'h6A200035, 1'b0, "andi");
      pr(GRB | ROUT | YIN, "andi.T3");
      pr(COUT | opf(5'b01101) | ZHIGHIN | ZLOWIN, "andi.T4");
      pr(ZLOWOUT | GRA | RIN, "andi.T5");
      drain();

      start(ir_of(5'b00011), 1'b0, "add");
      pr(GRB | ROUT | YIN, "add.T3");
      pr(GRC | ROUT | opf(5'b00011) | ZHIGHIN | ZLOWIN, "add.T4");
      pr(ZLOWOUT | GRA | RIN, "add.T5");
      drain();

      start(ir_of(5'b00001), 1'b0, "ldi");
      pr(GRB | BAOUT | YIN, "ldi.T3");
      pr(COUT | opf(5'b00011) | ZLOWIN, "ldi.T4");
      pr(ZLOWOUT | GRA | RIN, "ldi.T5");
      drain();

      start(ir_of(5'b00000), 1'b0, "ld");
      pr(GRB | BAOUT | YIN, "ld.T3");
      pr(COUT | opf(5'b00011) | ZLOWIN, "ld.T4");
      pr(ZLOWOUT | MARIN, "ld.T5");
      pr(READ | MDRIN, "ld.T6");
      pr(MDROUT | GRA | RIN, "ld.T7");
      drain();

      start(ir_of(5'b00010), 1'b0, "st");
      pr(GRB | BAOUT | YIN, "st.T3");
      pr(COUT | opf(5'b00011) | ZLOWIN, "st.T4");
      pr(ZLOWOUT | MARIN, "st.T5");
      pr(GRA | ROUT | MDRIN, "st.T6");
      pr(WRITE, "st.T7");
      drain();

      for (int k = 0; k < 2; k++) begin
         start(ir_of(5'b10011), k[0], k == 0 ? "br_nt" : "br_t");
         pr(GRA | ROUT | CONIN, "br.T3");
         pr(PCOUT | YIN, "br.T4");
         pr(COUT | opf(5'b00011) | ZLOWIN, "br.T5");
         pr(k == 0 ? ZERO : (ZLOWOUT | PCIN), k == 0 ? "br_nt.T6" : "br_t.T6");
         drain();
      end

      start(ir_of(5'b01111), 1'b0, "mul");
      pr(GRA | ROUT | YIN, "mul.T3");
      pr(GRB | ROUT | opf(5'b01111) | ZHIGHIN | ZLOWIN, "mul.T4");
      pr(ZLOWOUT | LOIN, "mul.T5");
      pr(ZHIGHOUT | HIIN, "mul.T6");
      drain();

      start(ir_of(5'b10010), 1'b0, "not");
      pr(GRB | ROUT | opf(5'b10010) | ZLOWIN, "not.T3");
      pr(ZLOWOUT | GRA | RIN, "not.T4");
      drain();

      start(ir_of(5'b10101), 1'b0, "jal");
      pr(PCOUT | GRB | RIN, "jal.T3");
      pr(GRA | ROUT | PCIN, "jal.T4");
      drain();

      start(ir_of(5'b10100), 1'b0, "jr");
      pr(GRA | ROUT | PCIN, "jr.T3");
      drain();
      start(ir_of(5'b10110), 1'b0, "in");
      pr(INPORT | GRA | RIN, "in.T3");
      drain();
      start(ir_of(5'b10111), 1'b0, "out");
      pr(GRA | ROUT | OUTPORT, "out.T3");
      drain();
      start(ir_of(5'b11000), 1'b0, "mfhi");
      pr(HIOUT | GRA | RIN, "mfhi.T3");
      drain();
      start(ir_of(5'b11001), 1'b0, "mflo");
      pr(LOOUT | GRA | RIN, "mflo.T3");
      drain();
      start(ir_of(5'b11010), 1'b0, "nop");
      drain();
      start(ir_of(5'b11101), 1'b0, "undef");
      drain();

      // Abort an add in the middle of T4.
      start(ir_of(5'b00011), 1'b0, "add_abort");
      pr(GRB | ROUT | YIN, "add_abort.T3");
      drain();
      #2;
      Clear = 1'b1;
      push(ZERO, "clear_mid_T4");
      drain();
      Clear = 1'b0;
      push(ZERO, "clear_release");

      start(ir_of(5'b11011), 1'b0, "halt");
      for (int k = 0; k < 12; k++) push(ZERO, "halt_hold");
      drain();
      Clear = 1'b1;
      push(ZERO, "halt_clear");
      drain();
      Clear = 1'b0;
      push(ZERO, "halt_release");
      start(ir_of(5'b11010), 1'b0, "restart_nop");
      pr(PCOUT | MARIN | INCPC | ZLOWIN, "restart_nop.next_T0");
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
